// File: rtl/common_pkg.sv
// Shared types and limits for the clock: command pulses, display modes, field limits.
package common_pkg;

  localparam int CLOCK_FREQ_DEFAULT = 2;

  localparam int   HOURS_MAX      = 23;
  localparam int   MINUTES_MAX    = 59;
  localparam int   SECONDS_MAX    = 59;
  localparam logic CURSOR_HOURS   = 1'b0;
  localparam logic CURSOR_MINUTES = 1'b1;

  typedef struct packed {
    logic do_display_time;
    logic do_set_time;
    logic do_set_alarm;
    logic do_toggle_alarm;
    logic do_left;
    logic do_up;
  } clock_op_t;

  typedef enum logic [1:0] {
    MODE_DISPLAY   = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } clock_mode_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_DISPLAY,
    CMD_SET_TIME,
    CMD_SET_ALARM,
    CMD_TOGGLE,
    CMD_LEFT,
    CMD_UP
  } clock_cmd_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle-per-second strobe; clear_i restarts the second.
module sec_prescaler #(
  parameter int CLK_FREQ_HZ = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick_o = (cnt == LAST) && !clear_i;

  always_ff @(posedge clk) begin
    if (rst || clear_i || (cnt == LAST)) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/clock_time_core.sv
// Executes button-controller commands: runs hh:mm:ss, edits time/alarm, rings the alarm.
module clock_time_core
  import common_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = CLOCK_FREQ_DEFAULT,
  parameter int ALARM_RING_SEC = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  clock_op_t   op_i,
  output logic [4:0]  disp_hh_o,
  output logic [5:0]  disp_mm_o,
  output logic [5:0]  disp_ss_o,
  output clock_mode_t mode_o,
  output logic        cursor_o,
  output logic        alarm_en_o,
  output logic        alarm_ring_o,
  output logic        sec_tick_o
);

  localparam int RW = $clog2(ALARM_RING_SEC + 1);
  localparam logic [RW-1:0] RING_LOAD = RW'(ALARM_RING_SEC);

  logic [4:0]    hh, nxt_hh, al_hh, buf_hh;
  logic [5:0]    mm, nxt_mm, ss, nxt_ss, al_mm, buf_mm;
  logic [RW-1:0] ring_cnt;
  clock_mode_t   mode;
  clock_cmd_t    cmd;
  logic          cursor, alarm_en, ring, tick, commit, alarm_hit;

  // One command per cycle, highest-priority bit wins.
  always_comb begin
    cmd = CMD_NONE;
    if      (op_i.do_display_time) cmd = CMD_DISPLAY;
    else if (op_i.do_set_time)     cmd = CMD_SET_TIME;
    else if (op_i.do_set_alarm)    cmd = CMD_SET_ALARM;
    else if (op_i.do_toggle_alarm) cmd = CMD_TOGGLE;
    else if (op_i.do_left)         cmd = CMD_LEFT;
    else if (op_i.do_up)           cmd = CMD_UP;
  end

  assign commit = (cmd == CMD_DISPLAY) && (mode == MODE_SET_TIME);

  sec_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear_i (commit),
    .tick_o  (tick)
  );

  always_comb begin
    nxt_ss = wrap_inc(ss, 6'(SECONDS_MAX));
    nxt_mm = mm;
    nxt_hh = hh;
    if (ss == 6'(SECONDS_MAX)) begin
      nxt_mm = wrap_inc(mm, 6'(MINUTES_MAX));
      if (mm == 6'(MINUTES_MAX)) nxt_hh = 5'(wrap_inc({1'b0, hh}, 6'(HOURS_MAX)));
    end
  end

  assign alarm_hit = alarm_en && (nxt_hh == al_hh) && (nxt_mm == al_mm) && (nxt_ss == 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hh         <= '0;
      mm         <= '0;
      ss         <= '0;
      al_hh      <= '0;
      al_mm      <= '0;
      buf_hh     <= '0;
      buf_mm     <= '0;
      mode       <= MODE_DISPLAY;
      cursor     <= CURSOR_HOURS;
      alarm_en   <= 1'b0;
      ring       <= 1'b0;
      ring_cnt   <= '0;
      sec_tick_o <= 1'b0;
    end else begin
      sec_tick_o <= tick;
      if (tick) begin
        hh <= nxt_hh;
        mm <= nxt_mm;
        ss <= nxt_ss;
      end

      unique case (cmd)
        CMD_SET_TIME: begin
          buf_hh <= hh;
          buf_mm <= mm;
          cursor <= CURSOR_HOURS;
          mode   <= MODE_SET_TIME;
        end
        CMD_SET_ALARM: begin
          buf_hh <= al_hh;
          buf_mm <= al_mm;
          cursor <= CURSOR_HOURS;
          mode   <= MODE_SET_ALARM;
        end
        CMD_DISPLAY: begin
          // The prescaler is cleared on commit, so no tick competes with this load.
          if (mode == MODE_SET_TIME) begin
            hh <= buf_hh;
            mm <= buf_mm;
            ss <= '0;
          end else if (mode == MODE_SET_ALARM) begin
            al_hh <= buf_hh;
            al_mm <= buf_mm;
          end
          mode <= MODE_DISPLAY;
        end
        CMD_LEFT: if (mode != MODE_DISPLAY) cursor <= ~cursor;
        CMD_UP: begin
          if (mode != MODE_DISPLAY) begin
            if (cursor == CURSOR_HOURS) buf_hh <= 5'(wrap_inc({1'b0, buf_hh}, 6'(HOURS_MAX)));
            else                        buf_mm <= wrap_inc(buf_mm, 6'(MINUTES_MAX));
          end
        end
        default: ;
      endcase

      // Silencing a ringing alarm also disarms it; otherwise toggle just flips the arm bit.
      if (cmd == CMD_TOGGLE) begin
        alarm_en <= ring ? 1'b0 : ~alarm_en;
        ring     <= 1'b0;
        ring_cnt <= '0;
      end else if (tick) begin
        if (alarm_hit) begin
          ring     <= 1'b1;
          ring_cnt <= RING_LOAD;
        end else if (ring) begin
          ring_cnt <= ring_cnt - 1'b1;
          if (ring_cnt == RW'(1)) ring <= 1'b0;
        end
      end
    end
  end

  assign disp_hh_o    = (mode == MODE_DISPLAY) ? hh : buf_hh;
  assign disp_mm_o    = (mode == MODE_DISPLAY) ? mm : buf_mm;
  assign disp_ss_o    = (mode == MODE_DISPLAY) ? ss : 6'd0;
  assign mode_o       = mode;
  assign cursor_o     = cursor;
  assign alarm_en_o   = alarm_en;
  assign alarm_ring_o = ring;

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
- Consumer end of the clock_op_t interface: receives single-cycle clock_do_* pulses from the button controller and executes them.
- Maintains real-time hh:mm:ss, an alarm hh:mm, the edit/set modes with a field cursor, and alarm enable/ring.
- Drives the binary time/edit values and mode/status flags consumed by the LCD formatter.

Parameters:
- CLK_FREQ_HZ, common_pkg::CLOCK_FREQ_DEFAULT (2), clk cycles per second; must be >= 1.
- ALARM_RING_SEC, 60, ring duration in seconds; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- op_i  in  clock_op_t (6)  command pulses; each bit high for one cycle
- disp_hh_o  out  5  hours shown, 0..23
- disp_mm_o  out  6  minutes shown, 0..59
- disp_ss_o  out  6  seconds shown, 0..59
- mode_o  out  clock_mode_t (2)  current mode
- cursor_o  out  1  edit field: 0 = hours, 1 = minutes
- alarm_en_o  out  1  alarm armed
- alarm_ring_o  out  1  alarm sounding
- sec_tick_o  out  1  one-cycle pulse when seconds advance

Behaviour:
- Reset values:
  - time 00:00:00, alarm 00:00, edit buffer 00:00, prescaler 0.
  - mode MODE_DISPLAY, cursor 0, alarm_en 0, ring 0, ring counter 0, sec_tick 0.
- Reset wins over every other input in the same cycle, including mid-edit; any edit in progress is discarded.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1, then wraps to 0.
  - On the edge after the count equals CLK_FREQ_HZ-1, the seconds field increments and registered sec_tick_o is 1 for exactly one cycle, coincident with the new time value.
  - First tick after reset: sec_tick_o high in cycle CLK_FREQ_HZ.
- Time arithmetic:
  - ss 59->0 carries into mm; mm 59->0 carries into hh; hh 23->0.
  - All fields stay binary and in range at all times.
- Timekeeping never stops, in any mode.
- Command decode:
  - Exactly one op acts per cycle, chosen by fixed priority: display_time > set_time > set_alarm > toggle_alarm > left > up.
  - Lower-priority bits set in the same cycle are ignored.
  - An all-zero op_i does nothing.
- FSM states: MODE_DISPLAY, MODE_SET_TIME, MODE_SET_ALARM.
  - set_time, any state: edit buffer <= current hh:mm, cursor <= 0, go to SET_TIME.
  - set_alarm, any state: edit buffer <= alarm hh:mm, cursor <= 0, go to SET_ALARM.
  - display_time in SET_TIME: time <= buffer hh:mm:00, prescaler <= 0, go to DISPLAY.
    - This overrides any tick in the same cycle: no increment, and sec_tick_o stays 0 next cycle.
  - display_time in SET_ALARM: alarm <= buffer, go to DISPLAY.
  - display_time in DISPLAY: no effect.
  - left in a SET state: cursor toggles. Ignored in DISPLAY.
  - up in a SET state: selected buffer field increments with wrap (hh 23->0, mm 59->0). Ignored in DISPLAY.
  - toggle_alarm, any state: alarm_en inverts. If ringing, ring clears and alarm_en becomes 0 regardless of its prior value.
- Display mux, combinational from registers:
  - DISPLAY: live hh:mm:ss.
  - SET modes: buffer hh:mm, disp_ss_o = 0.
- Alarm:
  - On a tick whose new time is alarm_hh:alarm_mm:00 with alarm_en = 1: ring <= 1, ring counter <= ALARM_RING_SEC.
  - Ring counter decrements on each subsequent tick. When it reaches 0, ring <= 0; alarm_en stays 1.
  - A match while already ringing restarts the counter.
  - Matching is active in all modes.
  - A time commit never triggers the alarm; only ticks do.

Decomposition:
- Add to common_pkg:
  - clock_mode_t enum logic [1:0]: MODE_DISPLAY = 0, MODE_SET_TIME = 1, MODE_SET_ALARM = 2.
  - localparams HOURS_MAX = 23, MINUTES_MAX = 59, SECONDS_MAX = 59, CURSOR_HOURS = 0, CURSOR_MINUTES = 1.
- Sub-module sec_prescaler, parameterized by CLK_FREQ_HZ:
  - Inputs clk, rst, clear_i; output tick_o.
  - clear_i (the time commit) zeroes the count and suppresses the tick.

Test Plan (CLK_FREQ_HZ = 2, ALARM_RING_SEC = 3):
- Free run: release rst, run 120 cycles -> display 00:01:00; sec_tick_o high every 2nd cycle, first in cycle 2.
- Edit and commit: set_time, up x3, left, up x2, display_time -> mode DISPLAY, time 03:02:00, next tick exactly 2 cycles after commit.
- Wrap: set time to 23:59, commit, run 60 ticks -> 00:00:00. Field wrap in edit: up x24 on hours -> 00.
- Alarm: set alarm 00:01, toggle_alarm (en = 1), run from 00:00:00 -> ring rises with the 00:01:00 tick and falls after 3 more ticks, en still 1. Repeat, issuing toggle_alarm mid-ring -> ring 0 and en 0 the next cycle.
- Simultaneous ops: in SET_TIME with buffer 05:10, op_i = display_time|up -> commit 05:10:00, no increment. In DISPLAY, op_i = left|up -> no change.
- Reset mid-edit: in SET_ALARM with buffer 07:00, assert rst one cycle -> DISPLAY, 00:00:00, alarm 00:00, all flags 0.
